// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions WIDTH independent bouncy push-button/switch inputs. Each raw
//   bit is brought into the clock domain through a two-flop synchronizer.
//   A per-channel FSM then accepts a new level only after it has persisted for
//   STABLE_CYCLES consecutive synchronized clocks. Edge pulses and a toggle
//   latch are derived at the moment of acceptance.
//
// Parameters
//   WIDTH         number of independent channels
//   STABLE_CYCLES consecutive synchronized clocks a new level must persist
//                 before acceptance (legal range 2..65535)
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   rst        synchronous, active-high reset
//   btn_raw    asynchronous bouncy board inputs, bit i = channel i
//   btn_db     debounced level per channel (registered)
//   btn_rise   one-clock pulse when btn_db bit goes 0->1
//   btn_fall   one-clock pulse when btn_db bit goes 1->0
//   btn_toggle per-channel latch that inverts on every btn_rise

module button_conditioner #(
  parameter int WIDTH         = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_db,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_fall,
  output logic [WIDTH-1:0] btn_toggle
);

  // The counter only has to reach STABLE_CYCLES-1, so it never wraps.
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  state_t           state     [WIDTH];
  state_t           state_nxt [WIDTH];
  logic [CNT_W-1:0] cnt       [WIDTH];
  logic [CNT_W-1:0] cnt_nxt   [WIDTH];

  logic [WIDTH-1:0] db_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;
  logic [WIDTH-1:0] toggle_nxt;

  // Two-flop synchronizer; sync2 is the only view of the raw inputs that the
  // rest of the design is allowed to see.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // State, counter and output registers for all channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE_LOW;
        cnt[i]   <= '0;
      end
      btn_db     <= '0;
      btn_rise   <= '0;
      btn_fall   <= '0;
      btn_toggle <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      btn_db     <= db_nxt;
      btn_rise   <= rise_nxt;
      btn_fall   <= fall_nxt;
      btn_toggle <= toggle_nxt;
    end
  end

  // Per-channel qualification. Entering a WAIT state already counts the
  // first matching sample, so acceptance happens on the STABLE_CYCLES-th
  // consecutive sample. Any opposite sample during a WAIT state returns to
  // the previous IDLE state without touching btn_db or btn_toggle.
  always_comb begin
    db_nxt     = btn_db;
    rise_nxt   = '0;
    fall_nxt   = '0;
    toggle_nxt = btn_toggle;
    for (int i = 0; i < WIDTH; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        IDLE_LOW: begin
          if (sync2[i]) begin
            state_nxt[i] = WAIT_HIGH;
            cnt_nxt[i]   = CNT_ONE;
          end else begin
            cnt_nxt[i] = '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2[i]) begin
            state_nxt[i] = IDLE_LOW;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i]  = IDLE_HIGH;
            cnt_nxt[i]    = '0;
            db_nxt[i]     = 1'b1;
            rise_nxt[i]   = 1'b1;
            toggle_nxt[i] = ~btn_toggle[i];
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!sync2[i]) begin
            state_nxt[i] = WAIT_LOW;
            cnt_nxt[i]   = CNT_ONE;
          end else begin
            cnt_nxt[i] = '0;
          end
        end
        WAIT_LOW: begin
          if (sync2[i]) begin
            state_nxt[i] = IDLE_HIGH;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = IDLE_LOW;
            cnt_nxt[i]   = '0;
            db_nxt[i]    = 1'b0;
            fall_nxt[i]  = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt[i] = IDLE_LOW;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed scenarios followed by a randomized phase. Every clock the DUT
//   outputs are compared with a run-length reference model: the design sees
//   the raw input two clocks late, and a channel's level flips once the
//   delayed input has differed from it for STABLE_CYCLES consecutive clocks.

module tb_button_conditioner;

  localparam int WIDTH  = 6;
  localparam int STABLE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] btn_raw = '0;
  logic [WIDTH-1:0] btn_db;
  logic [WIDTH-1:0] btn_rise;
  logic [WIDTH-1:0] btn_fall;
  logic [WIDTH-1:0] btn_toggle;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] m_d1, m_d2;
  logic [WIDTH-1:0] m_db, m_rise, m_fall, m_tog;
  int               m_run [WIDTH];

  always #5 clk = ~clk;

  button_conditioner #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_db     (btn_db),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .btn_toggle (btn_toggle)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock, given the inputs present before the edge.
  task automatic modelStep(input logic [WIDTH-1:0] raw, input logic r);
    logic [WIDTH-1:0] seen;
    if (r) begin
      m_d1 = '0; m_d2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_tog = '0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    end else begin
      seen   = m_d2;
      m_d2   = m_d1;
      m_d1   = raw;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < WIDTH; i++) begin
        m_run[i] = (seen[i] != m_db[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == STABLE) begin
          m_db[i]  = seen[i];
          m_run[i] = 0;
          if (seen[i]) begin
            m_rise[i] = 1'b1;
            m_tog[i]  = ~m_tog[i];
          end else begin
            m_fall[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("db",     32'(btn_db),     32'(m_db));
    checkVal("rise",   32'(btn_rise),   32'(m_rise));
    checkVal("fall",   32'(btn_fall),   32'(m_fall));
    checkVal("toggle", 32'(btn_toggle), 32'(m_tog));
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] raw, input logic r);
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    modelStep(raw, r);
    #1;
    checkOutput();
  endtask

  task automatic holdRaw(input logic [WIDTH-1:0] raw, input int n, input int ch,
                         output int rises, output int falls, output int first_rise);
    rises = 0; falls = 0; first_rise = 0;
    for (int k = 1; k <= n; k++) begin
      applyStimulus(raw, 1'b0);
      if (btn_rise[ch]) begin
        rises++;
        if (first_rise == 0) first_rise = k;
      end
      if (btn_fall[ch]) falls++;
    end
  endtask

  initial begin
    int r1, f1, e1, r2, f2, e2, first;
    logic [WIDTH-1:0] rv;
    logic [WIDTH-1:0] rr;
    logic [4:0] pat;

    // Reset
    for (int k = 0; k < 3; k++) applyStimulus('0, 1'b1);
    checkVal("reset_outputs", 32'({btn_db, btn_rise, btn_fall, btn_toggle}), 32'd0);

    // Clean press on channel 0
    holdRaw(6'b000001, 10, 0, r1, f1, e1);
    checkVal("press_rise_edge", e1, 6);
    checkVal("press_rise_count", r1, 1);
    checkVal("press_db", 32'(btn_db[0]), 32'd1);
    checkVal("press_toggle", 32'(btn_toggle[0]), 32'd1);
    holdRaw('0, 8, 0, r1, f1, e1);
    checkVal("release_fall_count", f1, 1);

    // Glitch rejection then minimal accepted pulse on channel 1
    holdRaw(6'b000010, 3, 1, r1, f1, e1);
    holdRaw('0, 8, 1, r2, f2, e2);
    checkVal("glitch3_rises", r1 + r2, 0);
    checkVal("glitch3_db", 32'(btn_db[1]), 32'd0);
    checkVal("glitch3_toggle", 32'(btn_toggle[1]), 32'd0);
    holdRaw(6'b000010, 4, 1, r1, f1, e1);
    holdRaw('0, 10, 1, r2, f2, e2);
    checkVal("pulse4_rises", r1 + r2, 1);
    checkVal("pulse4_falls", f1 + f2, 1);

    // Bounce on channel 2: press 1,0,1,0,1 then held
    pat = 5'b10101;
    r1 = 0; e1 = 0;
    for (int k = 1; k <= 15; k++) begin
      applyStimulus((k <= 5) ? {3'b000, pat[k-1], 2'b00} : 6'b000100, 1'b0);
      if (btn_rise[2]) begin
        r1++;
        if (e1 == 0) e1 = k;
      end
    end
    checkVal("bounce_rise_count", r1, 1);
    checkVal("bounce_rise_edge", e1, 10);
    // Release with bounce 0,1,0,1,0 then held low
    pat = 5'b01010;
    f1 = 0; r1 = 0;
    for (int k = 1; k <= 15; k++) begin
      applyStimulus((k <= 5) ? {3'b000, pat[k-1], 2'b00} : 6'b000000, 1'b0);
      if (btn_fall[2]) f1++;
      if (btn_rise[2]) r1++;
    end
    checkVal("bounce_fall_count", f1, 1);
    checkVal("bounce_release_rises", r1, 0);

    // Toggle on channel 3: three clean presses
    for (int p = 0; p < 3; p++) begin
      holdRaw(6'b001000, 6, 3, r1, f1, e1);
      checkVal($sformatf("toggle_press%0d", p), 32'(btn_toggle[3]), (p == 1) ? 32'd0 : 32'd1);
      holdRaw('0, 6, 3, r1, f1, e1);
    end
    checkVal("toggle_others", 32'(btn_toggle & 6'b110111), 32'(6'b000111));

    // Simultaneous press on all channels
    first = 0; rv = '0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(6'b111111, 1'b0);
      if (btn_rise != '0 && first == 0) begin
        first = k;
        rv    = btn_rise;
      end
    end
    checkVal("simul_rise_vec", 32'(rv), 32'(6'b111111));
    checkVal("simul_rise_edge", first, 6);
    checkVal("simul_db", 32'(btn_db), 32'(6'b111111));
    checkVal("simul_toggle", 32'(btn_toggle), 32'(6'b110000));
    holdRaw('0, 8, 0, r1, f1, e1);

    // Reset with channel 5 in IDLE_HIGH and channel 4 mid-count
    holdRaw(6'b100000, 8, 5, r1, f1, e1);
    holdRaw(6'b110000, 3, 4, r1, f1, e1);
    applyStimulus(6'b110000, 1'b1);
    checkVal("midrst_outputs", 32'({btn_db, btn_rise, btn_fall, btn_toggle}), 32'd0);
    first = 0; rv = '0;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(6'b110000, 1'b0);
      if (btn_rise[5] && first == 0) begin
        first = k;
        rv    = btn_rise;
      end
    end
    checkVal("midrst_rise5_edge", first, 6);
    checkVal("midrst_rise_vec", 32'(rv), 32'(6'b110000));

    // Randomized bouncy inputs with occasional resets
    rr = '0;
    for (int k = 0; k < 800; k++) begin
      for (int ch = 0; ch < WIDTH; ch++)
        if ($urandom_range(0, 4) == 0) rr[ch] = ~rr[ch];
      applyStimulus(rr, ($urandom_range(0, 149) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 6, meaning number of independent push-button/switch channels.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive synchronized clocks a new level must persist before acceptance; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port btn_raw, input, WIDTH bits: asynchronous, bouncy board inputs, bit i = channel i.
REQ-006 SHALL have port btn_db, output, WIDTH bits: debounced level per channel, registered; feeds downstream gate-level/operator logic.
REQ-007 SHALL have port btn_rise, output, WIDTH bits: one-clock pulse when btn_db bit goes 0->1.
REQ-008 SHALL have port btn_fall, output, WIDTH bits: one-clock pulse when btn_db bit goes 1->0.
REQ-009 SHALL have port btn_toggle, output, WIDTH bits: per-channel latch inverting on each btn_rise.

Function
REQ-010 SHALL pass each btn_raw bit through a two-flop synchronizer (sync1, sync2) before any other use; no other logic reads btn_raw.
REQ-011 SHALL implement per channel an independent FSM with states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW plus a counter cnt wide enough for STABLE_CYCLES-1 with no wrap.
REQ-012 SHALL, in IDLE_LOW: sync2=1 -> WAIT_HIGH, cnt<=1; else stay, cnt<=0.
REQ-013 SHALL, in WAIT_HIGH: sync2=0 -> IDLE_LOW, cnt<=0 (glitch rejected); sync2=1 and cnt=STABLE_CYCLES-1 -> IDLE_HIGH, btn_db<=1, btn_rise<=1, btn_toggle inverts, cnt<=0; else cnt<=cnt+1.
REQ-014 SHALL, in IDLE_HIGH: sync2=0 -> WAIT_LOW, cnt<=1; else stay, cnt<=0.
REQ-015 SHALL, in WAIT_LOW: sync2=1 -> IDLE_HIGH, cnt<=0; sync2=0 and cnt=STABLE_CYCLES-1 -> IDLE_LOW, btn_db<=0, btn_fall<=1, cnt<=0; else cnt<=cnt+1.
REQ-016 SHALL hold btn_rise and btn_fall at 0 in every clock except the single transition clock of REQ-013/015; never both high on one channel.
REQ-017 SHALL give latency: raw level stable from before edge 1 -> btn_db changes after edge 2+STABLE_CYCLES.
REQ-018 SHALL accept a raw pulse of exactly STABLE_CYCLES clocks and reject one of STABLE_CYCLES-1 clocks or shorter.
REQ-019 SHALL keep btn_db, btn_toggle unchanged on any rejected glitch, including glitches arriving in the last counting clock.
REQ-020 SHALL process channels fully independently; simultaneous events on several channels produce simultaneous, independent pulses.
REQ-021 SHALL hold state indefinitely while input is stable; counter never runs in IDLE states.

Reset
REQ-022 SHALL, on clk edge with rst=1, force sync1, sync2, btn_db, btn_rise, btn_fall, btn_toggle, cnt to 0 and all FSMs to IDLE_LOW, overriding every other transition.
REQ-023 SHALL, on rst asserted mid-count or in IDLE_HIGH, discard progress; after release a held button is re-qualified from IDLE_LOW and produces a fresh btn_rise at edge 2+STABLE_CYCLES after release.
REQ-024 SHALL produce no btn_rise/btn_fall pulse in the clock rst deasserts.

Verification (STABLE_CYCLES=4, WIDTH=6)
REQ-025 SHALL verify clean press: btn_raw[0] 0->1 before edge 1, held 10 clocks -> btn_db[0]=1 after edge 6, btn_rise[0]=1 for exactly that clock, btn_toggle[0]=1.
REQ-026 SHALL verify glitch rejection: btn_raw[1] high for 3 clocks then low -> btn_db[1], btn_rise[1], btn_toggle[1] stay 0; high for 4 clocks -> accepted.
REQ-027 SHALL verify bounce: btn_raw[2] pattern 1,0,1,0,1 then held 1 -> exactly one btn_rise[2], 6 clocks after final 0->1; release with bounce -> exactly one btn_fall[2].
REQ-028 SHALL verify toggle: three clean presses on channel 3 -> btn_toggle[3] sequence 1,0,1; other channels unchanged.
REQ-029 SHALL verify simultaneous: btn_raw=6'b111111 from 0 -> all btn_rise bits high in the same clock, btn_db=6'b111111.
REQ-030 SHALL verify reset mid-operation: rst pulsed while channel 4 in WAIT_HIGH and channel 5 in IDLE_HIGH -> all outputs 0 next clock; channel 5 still held -> new btn_rise[5] at edge 6 after release.
